// File: rtl/mux4_arbiter.sv
// mux4_arbiter
//   Round-robin arbiter and sequencer for the shared 4:1 single-bit mux path.
//   One requester is granted at a time; the registered grant index drives the
//   mux select lines and the granted requester's data bit is forwarded to out.
//   A hold limit (MAX_HOLD cycles per tenure) stops any requester from
//   monopolising the path; at expiry the holder drops to lowest priority.
//
//   Build option: define MUX4_ARB_FIXED_PRIO_EN to freeze the rotating
//   pointer at 3, giving fixed priority 0>1>2>3 (hold expiry still applies).
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles of one tenure (1..15)
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req[3:0]  request per requester
//   in0..in3  data bit of requester 0..3
//   grant     one-hot registered grant, zero when idle
//   address0  registered select LSB (bit 0 of granted index)
//   address1  registered select MSB (bit 1 of granted index)
//   out       data of granted requester, 0 when idle
//   busy      registered, 1 while a grant is active
module mux4_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] grant,
    output logic       address0,
    output logic       address1,
    output logic       out,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

    state_t     state, state_nx;
    logic [3:0] grant_nx;
    logic [1:0] addr, addr_nx;
    logic       busy_nx;
    logic [1:0] last, last_nx;
    logic [3:0] cnt, cnt_nx;
    logic       win_vld;
    logic [1:0] win_idx;
    logic       rearb;
    logic       sel_bit;

    // Search starts one past the last winner and wraps; offset 4 wraps back
    // to last itself, so the previous holder has the lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!win_vld && req[last + 2'(k)]) begin
                win_vld = 1'b1;
                win_idx = last + 2'(k);
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        addr_nx  = addr;
        busy_nx  = busy;
        last_nx  = last;
        cnt_nx   = cnt;
        rearb    = 1'b0;

        case (state)
            IDLE: begin
                rearb = 1'b1;
            end
            GRANT: begin
                // Release takes precedence over expiry; both re-arbitrate.
                if (!req[addr] || cnt >= CNT_MAX) begin
                    rearb = 1'b1;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                busy_nx  = 1'b0;
                cnt_nx   = '0;
            end
        endcase

        if (rearb) begin
            if (win_vld) begin
                state_nx = GRANT;
                grant_nx = 4'b0001 << win_idx;
                addr_nx  = win_idx;
                busy_nx  = 1'b1;
                cnt_nx   = '0;
`ifdef MUX4_ARB_FIXED_PRIO_EN
                last_nx  = 2'd3;
`else
                last_nx  = win_idx;
`endif
            end else begin
                state_nx = IDLE;
                grant_nx = '0;
                busy_nx  = 1'b0;
                cnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            addr  <= '0;
            busy  <= 1'b0;
            last  <= 2'd3;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            addr  <= addr_nx;
            busy  <= busy_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        case (addr)
            2'd0:    sel_bit = in0;
            2'd1:    sel_bit = in1;
            2'd2:    sel_bit = in2;
            default: sel_bit = in3;
        endcase
    end

    assign out      = sel_bit & busy;
    assign address0 = addr[0];
    assign address1 = addr[1];

endmodule
